multiport_regfile: RTL and testbench
====================================

# multiport_regfile

Parametrised general-purpose register file for the RISC datapath, replacing the fixed 32x32 two-read/one-write file. Provides `NREAD` combinational read ports and two write ports with a defined collision priority. Same-cycle write-to-read bypass and an optional hard-wired zero register are included. A handshaked dump engine streams every register out sequentially for debug and test observation, superseding the single `outty` probe.

## Interface
Parameters:
- `WIDTH`, 32, data width of each register
- `DEPTH`, 32, number of registers (2..256)
- `AW`, `$clog2(DEPTH)`, address width (derived; do not override)
- `NREAD`, 2, number of read ports (1..4)
- `ZEROREG`, 1, when 1 register 0 always reads 0 and ignores writes

Ports:
- `clock`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `readreg`  in  `NREAD*AW`  read addresses; port i at `[i*AW +: AW]`
- `readdata`  out  `NREAD*WIDTH`  read data; port i at `[i*WIDTH +: WIDTH]`
- `writereg0` / `writedata0` / `regwrite0`  in  `AW` / `WIDTH` / 1  write port 0
- `writereg1` / `writedata1` / `regwrite1`  in  `AW` / `WIDTH` / 1  write port 1 (higher priority)
- `dumpstart`  in  1  start a full-file dump (pulse)
- `dumpvalid`  out  1  dump beat valid
- `dumpready`  in  1  consumer accepts beat
- `dumpaddr`  out  `AW`  register index of current beat
- `dumpdata`  out  `WIDTH`  register content of current beat
- `dumpbusy`  out  1  dump in progress

## Operation
- Storage: `DEPTH` x `WIDTH` flops. Reset clears all registers to 0.
- Writes: a port with `regwrite*`=1 writes on the rising edge.
  - Both ports enabled to the same address: port 1 wins.
  - Address 0 with `ZEROREG`=1 is dropped.
  - Address >= `DEPTH` is dropped.
- Reads are combinational, with priority:
  - (a) address 0 with `ZEROREG`=1 returns 0;
  - (b) address >= `DEPTH` returns 0;
  - (c) `regwrite1` with a matching `writereg1` returns `writedata1`;
  - (d) `regwrite0` with a matching `writereg0` returns `writedata0`;
  - (e) otherwise returns the stored value.
- Dump FSM, states IDLE and DUMP:
  - IDLE: `dumpstart`=1 -> DUMP; pointer set to 0; `dumpdata` loaded with reg[0] post-edge value (including same-edge writes).
  - DUMP: `dumpvalid`=1, `dumpbusy`=1, `dumpaddr`=pointer.
    - On `dumpvalid && dumpready` with pointer < `DEPTH-1`: pointer increments and `dumpdata` loads the post-edge value of reg[pointer+1].
    - On an accepted beat with pointer = `DEPTH-1`: return to IDLE.
  - `dumpdata`/`dumpaddr` are held stable while stalled, even if that register is written meanwhile.
  - `dumpstart` is ignored in DUMP.
  - With `ZEROREG`=1, the reg[0] beat carries 0.

## Timing
- Reset values: `dumpvalid`=0, `dumpbusy`=0, `dumpaddr`=0, `dumpdata`=0, FSM=IDLE, all registers 0. `readdata` is then 0 for all addresses, absent active writes.
- Write latency: 1 edge. Read latency: 0 (same-cycle bypass).
- Dump: `dumpvalid` rises the edge after `dumpstart` is sampled. With `dumpready` held at 1, a dump takes exactly `DEPTH` cycles of `dumpvalid`.
- Reset asserted mid-dump aborts the dump immediately (asynchronous) and clears the file.
- Writes and reads remain fully functional during a dump; the dump never stalls the datapath.

## Structure
- Shared package `regfile_pkg`:
  - default `WIDTH`/`DEPTH` constants;
  - dump state enum `{DUMP_IDLE, DUMP_RUN}`.
- Sub-module `regfile_dump_fsm`: pointer, state, and the `dumpvalid`/`dumpbusy` logic. It receives the storage read-out and next-value bypass for the pointer index.
- Storage, write decode and read muxes live in the top module.

## Test plan
- Reset, then read all addresses on every port -> all `readdata` = 0, `dumpvalid`=0, `dumpbusy`=0.
- Write 0xDEADBEEF to r5 via port 0, read r5 in the same cycle -> bypass returns 0xDEADBEEF; next cycle the stored value is 0xDEADBEEF.
- Same edge: port 0 writes r7=0x11, port 1 writes r7=0x22 -> r7 reads 0x22; write 0x55 to r0 -> r0 reads 0.
- Preload r[i]=i+100 (r0=0), pulse `dumpstart` with `dumpready`=1 -> 32 beats, `dumpaddr` 0..31, data 0,101..131, then `dumpbusy` falls.
- Dump with `dumpready` toggling 1/0, writing r3=0xAAAA while beat 3 is stalled -> beat 3 keeps the pre-write value, with no beats lost or duplicated; assert `reset` at beat 10 -> outputs return to reset values next sample.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multiport register file and its dump engine.
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    typedef enum logic {
        DUMP_IDLE = 1'b0,
        DUMP_RUN  = 1'b1
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump engine: walks every register index once and presents each as a valid/ready beat.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_ready,
    input  logic [WIDTH-1:0]  i_next_data,
    output logic [AW-1:0]     o_next_ptr,
    output logic              o_valid,
    output logic [AW-1:0]     o_addr,
    output logic [WIDTH-1:0]  o_data,
    output dump_state_e       o_state
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    dump_state_e       r_state;
    dump_state_e       w_state_next;
    logic [AW-1:0]     r_ptr;
    logic [AW-1:0]     w_ptr_next;
    logic [WIDTH-1:0]  r_data;
    logic              w_load;

    // Handshake: a beat transfers on any rising edge where o_valid and i_ready are
    // both high; while i_ready is low, o_addr/o_data stay frozen on the current beat.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_load       = 1'b0;
        case (r_state)
            DUMP_IDLE: begin
                if (i_start) begin
                    w_state_next = DUMP_RUN;
                    w_ptr_next   = '0;
                    w_load       = 1'b1;
                end
            end
            DUMP_RUN: begin
                if (i_ready) begin
                    if (r_ptr == LAST_PTR) begin
                        w_state_next = DUMP_IDLE;
                    end else begin
                        w_ptr_next = r_ptr + 1'b1;
                        w_load     = 1'b1;
                    end
                end
            end
            default: w_state_next = DUMP_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= DUMP_IDLE;
            r_ptr   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            if (w_load) begin
                r_data <= i_next_data;
            end
        end
    end

    assign o_next_ptr = w_ptr_next;
    assign o_valid    = (r_state == DUMP_RUN);
    assign o_addr     = r_ptr;
    assign o_data     = r_data;
    assign o_state    = r_state;

endmodule

// File: rtl/multiport_regfile.sv
// Parametrised register file: NREAD bypassed read ports, two prioritised write ports,
// optional hard-wired zero register and a handshaked full-file dump stream.
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int AW      = $clog2(DEPTH),
    parameter int NREAD   = 2,
    parameter int ZEROREG = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREAD*AW-1:0]     readreg,
    output logic [NREAD*WIDTH-1:0]  readdata,
    input  logic [AW-1:0]           writereg0,
    input  logic [WIDTH-1:0]        writedata0,
    input  logic                    regwrite0,
    input  logic [AW-1:0]           writereg1,
    input  logic [WIDTH-1:0]        writedata1,
    input  logic                    regwrite1,
    input  logic                    dumpstart,
    output logic                    dumpvalid,
    input  logic                    dumpready,
    output logic [AW-1:0]           dumpaddr,
    output logic [WIDTH-1:0]        dumpdata,
    output logic                    dumpbusy
);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [AW-1:0]    w_dump_next_ptr;
    logic [WIDTH-1:0] w_dump_next_data;
    dump_state_e      w_dump_state;

    // Value register a will hold after the coming edge; doubles as the read bypass.
    function automatic logic [WIDTH-1:0] bypass_read(input logic [AW-1:0] a);
        if (ZEROREG != 0 && a == '0) begin
            return '0;
        end else if (32'(a) >= DEPTH) begin
            return '0;
        end else if (regwrite1 && writereg1 == a) begin
            return writedata1;
        end else if (regwrite0 && writereg0 == a) begin
            return writedata0;
        end else begin
            return r_regs[a];
        end
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ZEROREG == 0 || i != 0) begin
                    if (regwrite1 && writereg1 == AW'(i)) begin
                        r_regs[i] <= writedata1;
                    end else if (regwrite0 && writereg0 == AW'(i)) begin
                        r_regs[i] <= writedata0;
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_read
        assign readdata[p*WIDTH +: WIDTH] = bypass_read(readreg[p*AW +: AW]);
    end

    assign w_dump_next_data = bypass_read(w_dump_next_ptr);

    regfile_dump_fsm #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dump_fsm (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_start     (dumpstart),
        .i_ready     (dumpready),
        .i_next_data (w_dump_next_data),
        .o_next_ptr  (w_dump_next_ptr),
        .o_valid     (dumpvalid),
        .o_addr      (dumpaddr),
        .o_data      (dumpdata),
        .o_state     (w_dump_state)
    );

    assign dumpbusy = (w_dump_state == DUMP_RUN);

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench for multiport_regfile: reads, bypass, write priority, zero register and dumps.
module tb_multiport_regfile;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NREAD = 2;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NREAD*AW-1:0]    readreg;
    logic [NREAD*WIDTH-1:0] readdata;
    logic [AW-1:0]          writereg0, writereg1;
    logic [WIDTH-1:0]       writedata0, writedata1;
    logic                   regwrite0, regwrite1;
    logic                   dumpstart, dumpvalid, dumpready, dumpbusy;
    logic [AW-1:0]          dumpaddr;
    logic [WIDTH-1:0]       dumpdata;

    logic [31:0]      exp_q[$];
    logic [31:0]      beat_q[$];
    logic [WIDTH-1:0] m_regs [DEPTH];
    int               n_tests = 0;
    int               n_fail  = 0;

    multiport_regfile #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .NREAD   (NREAD),
        .ZEROREG (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .readreg    (readreg),
        .readdata   (readdata),
        .writereg0  (writereg0),
        .writedata0 (writedata0),
        .regwrite0  (regwrite0),
        .writereg1  (writereg1),
        .writedata1 (writedata1),
        .regwrite1  (regwrite1),
        .dumpstart  (dumpstart),
        .dumpvalid  (dumpvalid),
        .dumpready  (dumpready),
        .dumpaddr   (dumpaddr),
        .dumpdata   (dumpdata),
        .dumpbusy   (dumpbusy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        readreg[p*AW +: AW] = a;
    endtask

    function automatic logic [31:0] rd(input int p);
        return readdata[p*WIDTH +: WIDTH];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // sel 0 pops the read-result queue, sel 1 pops the dump-beat queue
    task automatic check_q(input string tag, input logic [31:0] obs, input int sel);
        logic [31:0] e;
        logic        empty;
        empty = (sel == 0) ? (exp_q.size() == 0) : (beat_q.size() == 0);
        if (empty) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed=%h expected=<queue empty>", tag, obs);
        end else begin
            e = (sel == 0) ? exp_q.pop_front() : beat_q.pop_front();
            check_eq(tag, obs, e);
        end
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        if (a != '0) m_regs[a] = d;
    endtask

    initial begin
        int  beats;
        int  idx;
        bit  done;
        bit  wrote;

        reset = 1'b1;
        readreg = '0;
        writereg0 = '0; writedata0 = '0; regwrite0 = 1'b0;
        writereg1 = '0; writedata1 = '0; regwrite1 = 1'b0;
        dumpstart = 1'b0; dumpready = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
        repeat (2) tick();
        reset = 1'b0;
        #1;

        check_eq("rst_dumpvalid", 32'(dumpvalid), 32'd0);
        check_eq("rst_dumpbusy",  32'(dumpbusy),  32'd0);
        check_eq("rst_dumpaddr",  32'(dumpaddr),  32'd0);
        check_eq("rst_dumpdata",  dumpdata,       32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, AW'(a));
            set_rd(1, AW'(DEPTH - 1 - a));
            exp_q.push_back(m_regs[a]);
            exp_q.push_back(m_regs[DEPTH - 1 - a]);
            tick();
            check_q("rst_read_p0", rd(0), 0);
            check_q("rst_read_p1", rd(1), 0);
        end

        // same-cycle bypass, then stored value
        regwrite0 = 1'b1; writereg0 = 5'd5; writedata0 = 32'hDEADBEEF;
        set_rd(0, 5'd5);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        check_q("bypass_r5", rd(0), 0);
        model_write(5'd5, 32'hDEADBEEF);
        tick();
        regwrite0 = 1'b0;
        exp_q.push_back(m_regs[5]);
        #1;
        check_q("stored_r5", rd(0), 0);

        // both ports to r7: port 1 wins
        regwrite0 = 1'b1; writereg0 = 5'd7; writedata0 = 32'h11;
        regwrite1 = 1'b1; writereg1 = 5'd7; writedata1 = 32'h22;
        set_rd(0, 5'd7); set_rd(1, 5'd7);
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h22);
        #1;
        check_q("collide_bypass_p0", rd(0), 0);
        check_q("collide_bypass_p1", rd(1), 0);
        model_write(5'd7, 32'h22);
        tick();
        regwrite0 = 1'b0; regwrite1 = 1'b0;
        exp_q.push_back(m_regs[7]);
        #1;
        check_q("collide_stored", rd(1), 0);

        // zero register ignores writes
        regwrite0 = 1'b1; writereg0 = 5'd0; writedata0 = 32'h55;
        set_rd(0, 5'd0);
        exp_q.push_back(32'h0);
        #1;
        check_q("r0_bypass", rd(0), 0);
        model_write(5'd0, 32'h55);
        tick();
        regwrite0 = 1'b0;
        exp_q.push_back(m_regs[0]);
        #1;
        check_q("r0_stored", rd(0), 0);

        // preload r[i] = i + 100 using both write ports
        for (int i = 1; i < DEPTH; i += 2) begin
            regwrite0 = 1'b1; writereg0 = AW'(i); writedata0 = 32'(i + 100);
            model_write(AW'(i), 32'(i + 100));
            if (i + 1 < DEPTH) begin
                regwrite1 = 1'b1; writereg1 = AW'(i + 1); writedata1 = 32'(i + 101);
                model_write(AW'(i + 1), 32'(i + 101));
            end else begin
                regwrite1 = 1'b0;
            end
            tick();
        end
        regwrite0 = 1'b0; regwrite1 = 1'b0;
        set_rd(0, 5'd31); set_rd(1, 5'd12);
        exp_q.push_back(32'd131);
        exp_q.push_back(32'd112);
        #1;
        check_q("preload_r31", rd(0), 0);
        check_q("preload_r12", rd(1), 0);

        // full dump with ready held high
        dumpready = 1'b1;
        dumpstart = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            beat_q.push_back(32'(a));
            beat_q.push_back(m_regs[a]);
        end
        tick();
        dumpstart = 1'b0;
        beats = 0;
        for (int c = 0; c < 2 * DEPTH && dumpvalid; c++) begin
            check_q("dump1_addr", 32'(dumpaddr), 1);
            check_q("dump1_data", dumpdata, 1);
            check_eq("dump1_busy", 32'(dumpbusy), 32'd1);
            beats++;
            tick();
        end
        check_eq("dump1_beats", 32'(beats), 32'(DEPTH));
        check_eq("dump1_busy_done", 32'(dumpbusy), 32'd0);
        beat_q.delete();

        // dump with toggling ready, write r3 while beat 3 stalls, reset at beat 10
        dumpready = 1'b0;
        dumpstart = 1'b1;
        for (int a = 0; a < 10; a++) begin
            beat_q.push_back(32'(a));
            beat_q.push_back(m_regs[a]);
        end
        tick();
        dumpstart = 1'b0;
        idx = 0; done = 1'b0; wrote = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            dumpready = c[0];
            #1;
            check_eq("dump2_valid", 32'(dumpvalid), 32'd1);
            if (!dumpready && dumpaddr == 5'd10) begin
                check_eq("dump2_beats_before_reset", 32'(idx), 32'd10);
                reset = 1'b1;
                #1;
                check_eq("abort_dumpvalid", 32'(dumpvalid), 32'd0);
                check_eq("abort_dumpbusy",  32'(dumpbusy),  32'd0);
                check_eq("abort_dumpaddr",  32'(dumpaddr),  32'd0);
                check_eq("abort_dumpdata",  dumpdata,       32'd0);
                for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
                set_rd(0, 5'd3); set_rd(1, 5'd31);
                exp_q.push_back(m_regs[3]);
                exp_q.push_back(m_regs[31]);
                #1;
                check_q("abort_read_r3", rd(0), 0);
                check_q("abort_read_r31", rd(1), 0);
                done = 1'b1;
            end else begin
                if (dumpready) begin
                    check_q("dump2_addr", 32'(dumpaddr), 1);
                    check_q("dump2_data", dumpdata, 1);
                    idx++;
                end else if (dumpaddr == 5'd3 && !wrote) begin
                    regwrite0 = 1'b1; writereg0 = 5'd3; writedata0 = 32'hAAAA;
                    set_rd(0, 5'd3);
                    exp_q.push_back(32'hAAAA);
                    #1;
                    check_q("bypass_r3_during_dump", rd(0), 0);
                    model_write(5'd3, 32'hAAAA);
                    wrote = 1'b1;
                end
                tick();
                regwrite0 = 1'b0;
            end
        end
        check_eq("dump2_reached_beat10", 32'(done), 32'd1);
        check_eq("dump2_beats_left", 32'(beat_q.size()), 32'd0);

        tick();
        reset = 1'b0;
        tick();
        check_eq("post_reset_dumpvalid", 32'(dumpvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
